// File: rtl/weight_fold_pkg.sv
// Shared types and helpers for the weight-fold two-port RAM.
// Optional feature macro: WFRAM_PARITY_EN (per-word even parity, see weight_fold_tpram).
package weight_fold_pkg;

  // Clear-sequencer states: walk the array after reset, then serve traffic
  typedef enum logic {
    WF_INIT = 1'b0,
    WF_RUN  = 1'b1
  } wf_state_e;

  // Supported read latencies (cycles from R_EN to R_VALID)
  localparam int WF_READ_LAT_MIN = 1;
  localparam int WF_READ_LAT_MAX = 2;

  // Low bit index of channel ch inside a packed multi-channel bus
  function automatic int chLo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/weight_fold_tpram_bank.sv
// One channel bank: simple dual-port inferred array with a registered read.
// Read-before-write: a same-address read and write in one cycle return the old word.
module wf_ram_bank
  import weight_fold_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [WIDTH-1:0]  wrData_i,
  input  logic              rdEn_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [WIDTH-1:0]  rdData_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdData_q;

  // Array write port and synchronous read register; both ports are range-checked by the caller
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
    if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/weight_fold_tpram.sv
// Multi-channel two-port weight RAM for the weight-fold path.
// Clears itself to INIT_VALUE after every reset, forwards same-cycle writes
// to colliding reads when FWD=1, returns zero for out-of-range reads, and
// offers a 1- or 2-cycle valid-qualified read port.
// Optional feature macro: WFRAM_PARITY_EN adds one even-parity bit per word
// and a sticky per-channel PAR_ERR; without it PAR_ERR is constant zero.
module weight_fold_tpram
  import weight_fold_pkg::*;
#(
  parameter int DATA_W   = 14,
  parameter int DEPTH    = 4096,
  parameter int CH       = 1,
  parameter int READ_LAT = 2,
  parameter int FWD      = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CH-1:0]        W_EN,
  input  logic [ADDR_W-1:0]    W_ADDR,
  input  logic [CH*DATA_W-1:0] W_DATA,
  input  logic                 R_EN,
  input  logic [ADDR_W-1:0]    R_ADDR,
  output logic [CH*DATA_W-1:0] R_DATA,
  output logic                 R_VALID,
  output logic                 INIT_BUSY,
  output logic [CH-1:0]        PAR_ERR
);

`ifdef WFRAM_PARITY_EN
  localparam int BANK_W = DATA_W + 1;
  localparam logic [BANK_W-1:0] INIT_WORD = {^INIT_VALUE, INIT_VALUE};
`else
  localparam int BANK_W = DATA_W;
  localparam logic [BANK_W-1:0] INIT_WORD = INIT_VALUE;
`endif

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (READ_LAT < WF_READ_LAT_MIN || READ_LAT > WF_READ_LAT_MAX) begin : gBadReadLat
    $error("weight_fold_tpram: READ_LAT must be 1 or 2");
  end

  wf_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  logic                initPhase, running, wrInRange, rdInRange, rdAccept;
  logic [CH-1:0]       fwdHit;

  logic                valid1_q, zero1_q;
  logic [CH-1:0]       fwdHit1_q;
  logic [CH*DATA_W-1:0] fwdData1_q;
  logic [CH*DATA_W-1:0] stage1Data;
  logic [CH-1:0]       stage1Err;

  logic [CH*DATA_W-1:0] outData;
  logic                outValid;
  logic [CH-1:0]       outPerr;

  assign initPhase = (state_q == WF_INIT) && !RST;
  assign running   = (state_q == WF_RUN) && !RST;
  assign wrInRange = ({1'b0, W_ADDR} < DEPTH_EXT);
  assign rdInRange = ({1'b0, R_ADDR} < DEPTH_EXT);
  assign rdAccept  = running && R_EN;

  // Clear sequencer next state: step the counter through every address once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == WF_INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_ADDR) begin
        state_d = WF_RUN;
        cnt_d   = '0;
      end
    end
  end

  // Clear sequencer registers; reset restarts the clear from address 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= WF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign INIT_BUSY = (state_q == WF_INIT);

  for (genvar c = 0; c < CH; c++) begin : gBank
    logic [DATA_W-1:0] wrSlice;
    logic [BANK_W-1:0] extWord;
    logic              bankWrEn;
    logic [ADDR_W-1:0] bankWrAddr;
    logic [BANK_W-1:0] bankWrData;
    logic [BANK_W-1:0] rdWord;

    assign wrSlice = W_DATA[chLo(c, DATA_W) +: DATA_W];
`ifdef WFRAM_PARITY_EN
    assign extWord = {^wrSlice, wrSlice};
`else
    assign extWord = wrSlice;
`endif

    assign bankWrEn   = initPhase || (running && W_EN[c] && wrInRange);
    assign bankWrAddr = initPhase ? cnt_q : W_ADDR;
    assign bankWrData = initPhase ? INIT_WORD : extWord;

    wf_ram_bank #(
      .WIDTH (BANK_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) uBank (
      .clk_i   (CLK),
      .wrEn_i  (bankWrEn),
      .wrAddr_i(bankWrAddr),
      .wrData_i(bankWrData),
      .rdEn_i  (rdAccept && rdInRange),
      .rdAddr_i(R_ADDR),
      .rdData_o(rdWord)
    );

    assign fwdHit[c] = (FWD != 0) && W_EN[c] && (W_ADDR == R_ADDR) && wrInRange;

    assign stage1Data[chLo(c, DATA_W) +: DATA_W] =
      zero1_q      ? '0 :
      fwdHit1_q[c] ? fwdData1_q[chLo(c, DATA_W) +: DATA_W] :
                     rdWord[DATA_W-1:0];

`ifdef WFRAM_PARITY_EN
    assign stage1Err[c] = !zero1_q && !fwdHit1_q[c] && (^rdWord);
`else
    assign stage1Err[c] = 1'b0;
`endif
  end

  // First read stage: side information travels alongside the bank read and only moves on an accepted read, so the result holds between reads
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid1_q   <= 1'b0;
      zero1_q    <= 1'b1;
      fwdHit1_q  <= '0;
      fwdData1_q <= '0;
    end else begin
      valid1_q <= rdAccept;
      if (rdAccept) begin
        zero1_q    <= !rdInRange;
        fwdHit1_q  <= fwdHit;
        fwdData1_q <= W_DATA;
      end
    end
  end

  if (READ_LAT == 2) begin : gLat2
    logic [CH*DATA_W-1:0] rdata2_q;
    logic                 valid2_q;
    logic [CH-1:0]        perr2_q;

    // Second output register, loaded only when the first stage holds a valid read
    always_ff @(posedge CLK) begin
      if (RST) begin
        rdata2_q <= '0;
        valid2_q <= 1'b0;
        perr2_q  <= '0;
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) begin
          rdata2_q <= stage1Data;
          perr2_q  <= stage1Err;
        end
      end
    end

    assign outData  = rdata2_q;
    assign outValid = valid2_q;
    assign outPerr  = perr2_q & {CH{valid2_q}};
  end else begin : gLat1
    assign outData  = stage1Data;
    assign outValid = valid1_q;
    assign outPerr  = stage1Err & {CH{valid1_q}};
  end

  assign R_DATA  = outData;
  assign R_VALID = outValid;

`ifdef WFRAM_PARITY_EN
  logic [CH-1:0] parErr_q;

  // Sticky parity error; the combinational term flags the error in the very R_VALID cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      parErr_q <= '0;
    end else begin
      parErr_q <= parErr_q | outPerr;
    end
  end

  assign PAR_ERR = parErr_q | outPerr;
`else
  assign PAR_ERR = outPerr;
`endif

endmodule
